// File: rtl/motor_pkg.sv
// motor_pkg: shared types, constants and the slew helper for the motor PWM scheduler
package motor_pkg;
  localparam int DUTY_W = 7;
  localparam int RPM_SHIFT = 6;
  typedef logic [DUTY_W-1:0] duty_t;
  typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;
  function automatic duty_t slew(input duty_t a, input duty_t t, input duty_t step);
    return t > a ? (t - a > step ? a + step : t) : (a - t > step ? a - step : t);
  endfunction
endpackage

// File: rtl/motor_pwm_sched_rpm_to_duty.sv
// rpm_to_duty: combinational RPM to PWM duty conversion with dead band and clamp
module rpm_to_duty
  import motor_pkg::*;
#(
  parameter int RPM_MIN  = 500,
  parameter int DUTY_MAX = 90
) (
  input  logic [15:0] rpm,
  output duty_t       duty
);
  logic [15:0] d;
  assign d = (rpm - 16'(RPM_MIN)) >> RPM_SHIFT;
  assign duty = rpm <= 16'(RPM_MIN) ? '0 : d > 16'(DUTY_MAX) ? duty_t'(DUTY_MAX) : duty_t'(d);
endmodule

// File: rtl/motor_pwm_sched.sv
// motor_pwm_sched: four-channel motor PWM scheduler with arming, slew limiting and command-loss failsafe
module motor_pwm_sched
  import motor_pkg::*;
#(
  parameter int NUM_MOT         = 4,
  parameter int PRESC_DIV       = 25,
  parameter int PERIOD_CNT      = 100,
  parameter int DUTY_MAX        = 90,
  parameter int RPM_MIN         = 500,
  parameter int SLEW_STEP       = 10,
  parameter int ARM_PERIODS     = 8,
  parameter int TIMEOUT_PERIODS = 50
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm_req,
  input  logic                       disarm_req,
  input  logic                       rpm_valid,
  output logic                       rpm_ready,
  input  logic [$clog2(NUM_MOT)-1:0] rpm_id,
  input  logic [15:0]                rpm_val,
  output logic [NUM_MOT-1:0]         pwm_o,
  output logic [NUM_MOT*DUTY_W-1:0]  duty_o,
  output logic                       armed,
  output logic                       period_start,
  output logic                       timeout
);
  localparam int IW = $clog2(NUM_MOT);
  localparam int PW = $clog2(PRESC_DIV);
  localparam int CW = $clog2(PERIOD_CNT);
  localparam int AW = $clog2(ARM_PERIODS);
  localparam int WW = $clog2(TIMEOUT_PERIODS + 1);
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [CW-1:0] pwm_cnt;
  logic [AW-1:0] arm_cnt;
  logic [WW-1:0] wd_cnt;
  logic seen, tick, bnd, acc, fire, clr;
  duty_t conv;
  assign tick = presc == PW'(PRESC_DIV - 1);
  assign bnd = tick && pwm_cnt == CW'(PERIOD_CNT - 1);
  assign armed = state == ARMED;
  assign rpm_ready = armed;
  assign acc = rpm_valid && rpm_ready;
  assign clr = disarm_req || state == DISARMED;
  // seen marks an accept earlier in the current period, so that period does not count as idle
  assign fire = armed && bnd && !acc && !seen && wd_cnt == WW'(TIMEOUT_PERIODS - 1);
  rpm_to_duty #(.RPM_MIN(RPM_MIN), .DUTY_MAX(DUTY_MAX)) u_conv (
    .rpm (rpm_val),
    .duty(conv)
  );
  always_comb begin
    state_n = disarm_req ? DISARMED :
              (state == DISARMED && arm_req) ? ARMING :
              (state == ARMING && bnd && arm_cnt == AW'(ARM_PERIODS - 1)) ? ARMED : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DISARMED;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      pwm_cnt <= '0;
      arm_cnt <= '0;
      period_start <= 1'b0;
    end else if (disarm_req) begin
      presc <= '0;
      pwm_cnt <= '0;
      arm_cnt <= '0;
      period_start <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= bnd ? '0 : tick ? pwm_cnt + 1'b1 : pwm_cnt;
      arm_cnt <= state != ARMING ? '0 : bnd ? arm_cnt + 1'b1 : arm_cnt;
      period_start <= bnd;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      seen <= 1'b0;
      timeout <= 1'b0;
    end else if (disarm_req || !armed) begin
      wd_cnt <= '0;
      seen <= 1'b0;
      timeout <= 1'b0;
    end else if (acc) begin
      wd_cnt <= '0;
      seen <= !bnd;
      timeout <= 1'b0;
    end else if (bnd) begin
      wd_cnt <= seen ? '0 : wd_cnt == WW'(TIMEOUT_PERIODS) ? wd_cnt : wd_cnt + 1'b1;
      seen <= 1'b0;
      timeout <= timeout || fire;
    end
  end
  for (genvar i = 0; i < NUM_MOT; i++) begin : g_ch
    duty_t act, tgt;
    // an accept on a boundary edge lands in tgt after the slew has already sampled the old value
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        act <= '0;
        tgt <= '0;
      end else if (clr) begin
        act <= '0;
        tgt <= '0;
      end else begin
        if (bnd) act <= slew(act, tgt, duty_t'(SLEW_STEP));
        if (fire) tgt <= '0;
        else if (acc && rpm_id == IW'(i)) tgt <= conv;
      end
    end
    assign pwm_o[i] = armed && 32'(pwm_cnt) < 32'(act);
    assign duty_o[i*DUTY_W +: DUTY_W] = act;
  end
endmodule
